// File: rtl/mc_sequencer_pkg.sv
// rtl/mc_sequencer_pkg.sv - opcode map, state/class encodings and alu_op codes for mc_sequencer
package mc_sequencer_pkg;

  localparam logic [3:0] OP_LW       = 4'b0000;
  localparam logic [3:0] OP_SW       = 4'b0001;
  localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
  localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ      = 4'b1011;
  localparam logic [3:0] OP_BNE      = 4'b1100;
  localparam logic [3:0] OP_J        = 4'b1101;

  localparam logic [1:0] ALUOP_FUNC = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_MEM  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_LW    = 3'd0,
    CL_SW    = 3'd1,
    CL_RTYPE = 3'd2,
    CL_BR    = 3'd3,
    CL_J     = 3'd4,
    CL_ILL   = 3'd5
  } op_class_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - control bundle between sequencer and datapath/data memory
interface mc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             jump;
  logic             beq;
  logic             bne;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic [1:0]       alu_op;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, jump, beq, bne, mem_read, mem_write,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op, illegal, mem_err, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, jump, beq, bne, mem_read, mem_write,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op, illegal, mem_err, retired
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - combinational opcode to instruction class
module mc_opcode_decode
  import mc_sequencer_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CL_ILL;
    if (op == OP_LW)
      op_class = CL_LW;
    else if (op == OP_SW)
      op_class = CL_SW;
    else if (op >= OP_RTYPE_LO && op <= OP_RTYPE_HI)
      op_class = CL_RTYPE;
    else if (op == OP_BEQ || op == OP_BNE)
      op_class = CL_BR;
    else if (op == OP_J)
      op_class = CL_J;
  end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  mc_sequencer_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t           state;
  logic [3:0]       op_q;
  logic [7:0]       wait_ctr;
  logic [CNT_W-1:0] retired_q;

  logic [3:0] op_sel;
  op_class_t  op_class;
  logic       mem_timeout;

  logic       pc_write_c, ir_write_c, jump_c, beq_c, bne_c;
  logic       mem_read_c, mem_write_c, alu_src_c, reg_dst_c;
  logic       mem_to_reg_c, reg_write_c, illegal_c, mem_err_c;
  logic [1:0] alu_op_c;

  // DECODE must classify the live opcode so an illegal op retires in that same cycle
  assign op_sel      = (state == ST_DECODE) ? bus.opcode : op_q;
  assign mem_timeout = !bus.mem_ready && (wait_ctr == WAIT_LAST);

  mc_opcode_decode u_decode (
    .op       (op_sel),
    .op_class (op_class)
  );

  // Control lines follow the state directly; MEM completion and illegal retire
  // react to mem_ready/opcode within the cycle to keep the stated latencies.
  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    jump_c       = 1'b0;
    beq_c        = 1'b0;
    bne_c        = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_op_c     = ALUOP_FUNC;
    illegal_c    = 1'b0;
    mem_err_c    = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: ir_write_c = 1'b1;
        ST_DECODE: begin
          if (op_class == CL_ILL) begin
            illegal_c  = 1'b1;
            pc_write_c = 1'b1;
          end
        end
        ST_EXEC: begin
          case (op_class)
            CL_LW, CL_SW: begin
              alu_src_c = 1'b1;
              alu_op_c  = ALUOP_MEM;
            end
            CL_RTYPE: reg_dst_c = 1'b1;
            CL_BR: begin
              alu_op_c   = ALUOP_BR;
              beq_c      = (op_q != OP_BNE);
              bne_c      = (op_q == OP_BNE);
              pc_write_c = 1'b1;
            end
            CL_J: begin
              jump_c     = 1'b1;
              pc_write_c = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          alu_src_c   = 1'b1;
          alu_op_c    = ALUOP_MEM;
          mem_read_c  = (op_class == CL_LW);
          mem_write_c = (op_class == CL_SW);
          if (bus.mem_ready) begin
            pc_write_c = (op_class != CL_LW);
          end else if (mem_timeout) begin
            mem_err_c  = 1'b1;
            pc_write_c = 1'b1;
          end
        end
        ST_WB: begin
          reg_write_c = 1'b1;
          pc_write_c  = 1'b1;
          if (op_class == CL_LW) begin
            mem_to_reg_c = 1'b1;
            mem_read_c   = 1'b1;
            alu_src_c    = 1'b1;
            alu_op_c     = ALUOP_MEM;
          end else begin
            reg_dst_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      op_q      <= '0;
      wait_ctr  <= '0;
      retired_q <= '0;
    end else begin
      if (pc_write_c && !mem_err_c)
        retired_q <= retired_q + CNT_W'(1);
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          op_q  <= bus.opcode;
          state <= (op_class == CL_ILL) ? ST_FETCH : ST_EXEC;
        end
        ST_EXEC: begin
          wait_ctr <= '0;
          case (op_class)
            CL_LW, CL_SW: state <= ST_MEM;
            CL_RTYPE:     state <= ST_WB;
            default:      state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready)
            state <= (op_class == CL_LW) ? ST_WB : ST_FETCH;
          else if (mem_timeout)
            state <= ST_FETCH;
          else
            wait_ctr <= wait_ctr + 8'd1;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign bus.pc_write   = pc_write_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.jump       = jump_c;
  assign bus.beq        = beq_c;
  assign bus.bne        = bne_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.illegal    = illegal_c;
  assign bus.mem_err    = mem_err_c;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - table-driven check of mc_sequencer cycle-by-cycle controls
module tb_mc_sequencer;

  localparam logic [14:0] O_PCW   = 15'h4000;
  localparam logic [14:0] O_IR    = 15'h2000;
  localparam logic [14:0] O_JMP   = 15'h1000;
  localparam logic [14:0] O_BEQ   = 15'h0800;
  localparam logic [14:0] O_BNE   = 15'h0400;
  localparam logic [14:0] O_MRD   = 15'h0200;
  localparam logic [14:0] O_MWR   = 15'h0100;
  localparam logic [14:0] O_ASRC  = 15'h0080;
  localparam logic [14:0] O_RDST  = 15'h0040;
  localparam logic [14:0] O_M2R   = 15'h0020;
  localparam logic [14:0] O_RWR   = 15'h0010;
  localparam logic [14:0] O_AOP10 = 15'h0008;
  localparam logic [14:0] O_AOP01 = 15'h0004;
  localparam logic [14:0] O_ILL   = 15'h0002;
  localparam logic [14:0] O_MERR  = 15'h0001;
  localparam logic [14:0] MEMLD   = O_ASRC | O_AOP10;

  localparam logic [3:0] T_LW  = 4'b0000;
  localparam logic [3:0] T_SW  = 4'b0001;
  localparam logic [3:0] T_ADD = 4'b0010;
  localparam logic [3:0] T_BEQ = 4'b1011;
  localparam logic [3:0] T_BNE = 4'b1100;
  localparam logic [3:0] T_J   = 4'b1101;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        rdy;
    logic [14:0] exp;
    logic [2:0]  ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];

  mc_sequencer_if #(.CNT_W(3)) bus ();

  mc_sequencer #(.MEM_WAIT_MAX(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] outs();
    return {bus.pc_write, bus.ir_write, bus.jump, bus.beq, bus.bne, bus.mem_read,
            bus.mem_write, bus.alu_src, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.alu_op, bus.illegal, bus.mem_err};
  endfunction

  task automatic add(input logic r, input logic [3:0] o, input logic rd,
                     input logic [14:0] e, input logic [2:0] rt);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = rd; v.exp = e; v.ret = rt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] o, input logic rd);
    @(posedge clk);
    #1;
    reset         = r;
    bus.opcode    = o;
    bus.mem_ready = rd;
    #4;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int found;
    reset         = 1'b1;
    bus.opcode    = 4'b0000;
    bus.mem_ready = 1'b0;

    // ADD, LW with 3 wait cycles, SW timeout, BEQ, J, BNE, illegals, SW immediate (counter wraps)
    add(0, T_ADD, 0, O_IR, 0);
    add(0, T_ADD, 0, 15'h0, 0);
    add(0, T_ADD, 0, O_RDST, 0);
    add(0, T_ADD, 0, O_RDST | O_RWR | O_PCW, 0);
    add(0, T_LW, 0, O_IR, 1);
    add(0, T_LW, 0, 15'h0, 1);
    add(0, T_LW, 0, MEMLD, 1);
    for (int i = 0; i < 3; i++) add(0, T_LW, 0, MEMLD | O_MRD, 1);
    add(0, T_LW, 1, MEMLD | O_MRD, 1);
    add(0, T_LW, 0, MEMLD | O_MRD | O_M2R | O_RWR | O_PCW, 1);
    add(0, T_SW, 0, O_IR, 2);
    add(0, T_SW, 0, 15'h0, 2);
    add(0, T_SW, 0, MEMLD, 2);
    for (int i = 0; i < 3; i++) add(0, T_SW, 0, MEMLD | O_MWR, 2);
    add(0, T_SW, 0, MEMLD | O_MWR | O_MERR | O_PCW, 2);
    add(0, T_BEQ, 0, O_IR, 2);
    add(0, T_BEQ, 0, 15'h0, 2);
    add(0, T_BEQ, 0, O_AOP01 | O_BEQ | O_PCW, 2);
    add(0, T_J, 0, O_IR, 3);
    add(0, T_J, 0, 15'h0, 3);
    add(0, T_J, 0, O_JMP | O_PCW, 3);
    add(0, T_BNE, 0, O_IR, 4);
    add(0, T_BNE, 0, 15'h0, 4);
    add(0, T_BNE, 0, O_AOP01 | O_BNE | O_PCW, 4);
    add(0, 4'b1111, 0, O_IR, 5);
    add(0, 4'b1111, 0, O_ILL | O_PCW, 5);
    add(0, 4'b1010, 0, O_IR, 6);
    add(0, 4'b1010, 0, O_ILL | O_PCW, 6);
    add(0, 4'b1110, 0, O_IR, 7);
    add(0, 4'b1110, 0, O_ILL | O_PCW, 7);
    add(0, T_SW, 0, O_IR, 0);
    add(0, T_SW, 0, 15'h0, 0);
    add(0, T_SW, 0, MEMLD, 0);
    add(0, T_SW, 1, MEMLD | O_MWR | O_PCW, 0);
    add(0, T_LW, 0, O_IR, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 0, {1'b0, outs()}, 16'h0);
    chk("reset_retired", 0, {13'h0, bus.retired}, 16'h0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy);
      chk("vec_outs", i, {1'b0, outs()}, {1'b0, tbl[i].exp});
      chk("vec_retired", i, {13'h0, bus.retired}, {13'h0, tbl[i].ret});
      chk("rd_wr_excl", i, {15'h0, bus.mem_read & bus.mem_write}, 16'h0);
    end

    // reset while LW waits in MEM, with mem_ready arriving in the same cycle
    step(0, T_LW, 0);
    step(0, T_LW, 0);
    chk("lw_exec", 0, {1'b0, outs()}, {1'b0, MEMLD});
    step(0, T_LW, 0);
    chk("lw_mem", 0, {1'b0, outs()}, {1'b0, MEMLD | O_MRD});
    step(1, T_LW, 1);
    chk("rst_in_mem", 0, {1'b0, outs()}, 16'h0);
    step(0, T_ADD, 0);
    chk("post_rst_fetch", 0, {1'b0, outs()}, {1'b0, O_IR});
    chk("post_rst_retired", 0, {13'h0, bus.retired}, 16'h0);

    // LW with mem_ready after two wait cycles, WB awaited under a cycle budget
    step(0, T_LW, 0);
    step(0, T_LW, 0);
    found = -1;
    for (int k = 0; k < 20; k++) begin
      step(0, T_LW, (k >= 2));
      if (bus.reg_write) begin
        found = k;
        break;
      end
    end
    if (found < 0) begin
      total++;
      bad++;
      $display("FAIL lw_wb_budget got=none want=reg_write within 20 cycles");
    end else begin
      chk("lw_wb_cycle", 0, 16'(found), 16'd3);
      chk("lw_wb_outs", 0, {1'b0, outs()}, {1'b0, MEMLD | O_MRD | O_M2R | O_RWR | O_PCW});
    end
    step(0, T_ADD, 0);
    chk("lw_retired", 0, {13'h0, bus.retired}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
